maxpool_ctrl: RTL and testbench

- Reader for the conv-layer output RAM. It consumes the feature map written by the convolution controller after that controller raises finish.
- Performs 2x2 stride-2 signed max pooling per channel and writes the pooled map into a next-layer input RAM.
- Drives both RAMs directly through the standard ram interface: address, read_enable, write_enable, data_in/data_out; 1-cycle synchronous read.

---
 rtl/maxpool_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_maxpool_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 signed max-pool reader/writer between the conv-output RAM and the next-layer RAM.
// Define MAXPOOL_RELU_EN to clamp negative pooled samples to zero (fused ReLU).
module maxpool_ctrl #(
    parameter int IN_W     = 32,
    parameter int IN_H     = 32,
    parameter int CHANNELS = 32,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_ctrl,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              en_read,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              en_write,
    output logic              busy,
    output logic              finish,
    output logic [2:0]        dbg_state
);

    localparam int OUT_W    = IN_W / 2;
    localparam int OUT_H    = IN_H / 2;
    localparam int PLANE    = IN_H * IN_W;
    localparam int OPLANE   = OUT_H * OUT_W;
    localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ROW_BITS = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int COL_BITS = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CH_BITS-1:0]  r_ch;
    logic [ROW_BITS-1:0] r_row;
    logic [COL_BITS-1:0] r_col;
    logic [1:0]          r_k;
    logic [DATA_W-1:0]   r_max;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_en_write;
    logic                r_busy;
    logic                r_finish;

    logic                w_last_col;
    logic                w_last_row;
    logic                w_last_ch;
    logic                w_last_win;
    logic [ADDR_W-1:0]   w_in_addr;
    logic [ADDR_W-1:0]   w_out_addr;
    logic [DATA_W-1:0]   w_max_next;
    logic [DATA_W-1:0]   w_pool_val;
    logic                w_nxt_en_write;
    logic                w_nxt_busy;
    logic                w_nxt_finish;
    logic [ADDR_W-1:0]   w_nxt_wr_addr;
    logic [DATA_W-1:0]   w_nxt_wr_data;

    assign w_last_col = (r_col == COL_BITS'(OUT_W - 1));
    assign w_last_row = (r_row == ROW_BITS'(OUT_H - 1));
    assign w_last_ch  = (r_ch == CH_BITS'(CHANNELS - 1));
    assign w_last_win = w_last_col && w_last_row && w_last_ch;

    // k[1] picks the lower row of the window, k[0] the right column.
    assign w_in_addr  = ADDR_W'(32'(r_ch) * PLANE
                              + (32'(r_row) * 2 + 32'(r_k[1])) * IN_W
                              + 32'(r_col) * 2 + 32'(r_k[0]));
    assign w_out_addr = ADDR_W'(32'(r_ch) * OPLANE + 32'(r_row) * OUT_W + 32'(r_col));

    // Ties keep the held value, so only a strictly larger sample replaces it.
    assign w_max_next = ($signed(rd_data) > $signed(r_max)) ? rd_data : r_max;

`ifdef MAXPOOL_RELU_EN
    assign w_pool_val = w_max_next[DATA_W-1] ? '0 : w_max_next;
`else
    assign w_pool_val = w_max_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (en_ctrl) w_next_state = S_FETCH;
            S_FETCH: if (r_k == 2'd3) w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = S_WRITE;
            S_WRITE: w_next_state = w_last_win ? S_DONE : S_FETCH;
            S_DONE:  if (!en_ctrl) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Read port is decoded combinationally so the RAM captures the address at the next edge;
    // everything else is the registered image of the next state.
    always_comb begin
        en_read        = (r_state == S_FETCH);
        rd_addr        = (r_state == S_FETCH) ? w_in_addr : '0;
        w_nxt_en_write = (w_next_state == S_WRITE);
        w_nxt_busy     = (w_next_state == S_FETCH) || (w_next_state == S_DRAIN) ||
                         (w_next_state == S_WRITE);
        w_nxt_finish   = (w_next_state == S_DONE);
        w_nxt_wr_addr  = (w_next_state == S_WRITE) ? w_out_addr : r_wr_addr;
        w_nxt_wr_data  = (w_next_state == S_WRITE) ? w_pool_val : r_wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ch  <= '0;
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
            r_max <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en_ctrl) begin
                        r_ch  <= '0;
                        r_row <= '0;
                        r_col <= '0;
                        r_k   <= '0;
                    end
                end
                S_FETCH: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd1) begin
                        r_max <= rd_data;
                    end else if (r_k != 2'd0) begin
                        r_max <= w_max_next;
                    end
                end
                S_DRAIN: r_max <= w_max_next;
                S_WRITE: begin
                    if (w_last_col) begin
                        r_col <= '0;
                        if (w_last_row) begin
                            r_row <= '0;
                            r_ch  <= w_last_ch ? '0 : r_ch + CH_BITS'(1);
                        end else begin
                            r_row <= r_row + ROW_BITS'(1);
                        end
                    end else begin
                        r_col <= r_col + COL_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_en_write <= 1'b0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
        end else begin
            r_wr_addr  <= w_nxt_wr_addr;
            r_wr_data  <= w_nxt_wr_data;
            r_en_write <= w_nxt_en_write;
            r_busy     <= w_nxt_busy;
            r_finish   <= w_nxt_finish;
        end
    end

    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign en_write  = r_en_write;
    assign busy      = r_busy;
    assign finish    = r_finish;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Directed bench for maxpool_ctrl: 2x2x1, 4x4x2 and default-size instances with behavioural RAMs.
// Build with MAXPOOL_RELU_EN defined to check the fused-ReLU variant.
module tb_maxpool_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

`ifdef MAXPOOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    function automatic logic [7:0] pool_exp(input logic [7:0] v);
        return (RELU && v[7]) ? 8'd0 : v;
    endfunction

    // ---------------- small instance: 2x2, 1 channel
    logic        s_en = 1'b0, s_en_read, s_en_write, s_busy, s_finish;
    logic [15:0] s_rd_addr, s_wr_addr;
    logic [7:0]  s_rd_data, s_wr_data;
    logic [2:0]  s_dbg;
    logic [7:0]  s_in [0:65535];
    logic [7:0]  s_out [0:65535];

    maxpool_ctrl #(.IN_W(2), .IN_H(2), .CHANNELS(1)) u_small (
        .clk(clk), .reset(reset), .en_ctrl(s_en),
        .rd_addr(s_rd_addr), .en_read(s_en_read), .rd_data(s_rd_data),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .en_write(s_en_write),
        .busy(s_busy), .finish(s_finish), .dbg_state(s_dbg)
    );

    always @(posedge clk) begin
        if (s_en_read) s_rd_data <= s_in[s_rd_addr];
        if (s_en_write) s_out[s_wr_addr] <= s_wr_data;
    end

    // ---------------- mid instance: 4x4, 2 channels
    logic        m_en = 1'b0, m_en_read, m_en_write, m_busy, m_finish;
    logic [15:0] m_rd_addr, m_wr_addr;
    logic [7:0]  m_rd_data, m_wr_data;
    logic [2:0]  m_dbg;
    logic [7:0]  m_in [0:65535];

    maxpool_ctrl #(.IN_W(4), .IN_H(4), .CHANNELS(2)) u_mid (
        .clk(clk), .reset(reset), .en_ctrl(m_en),
        .rd_addr(m_rd_addr), .en_read(m_en_read), .rd_data(m_rd_data),
        .wr_addr(m_wr_addr), .wr_data(m_wr_data), .en_write(m_en_write),
        .busy(m_busy), .finish(m_finish), .dbg_state(m_dbg)
    );

    always @(posedge clk) begin
        if (m_en_read) m_rd_data <= m_in[m_rd_addr];
    end

    // ---------------- full instance: default parameters
    logic        f_en = 1'b0, f_en_read, f_en_write, f_busy, f_finish;
    logic [15:0] f_rd_addr, f_wr_addr;
    logic [7:0]  f_rd_data, f_wr_data;
    logic [2:0]  f_dbg;
    logic [7:0]  f_in [0:65535];
    logic [7:0]  f_out [0:65535];
    int          f_wcount = 0;

    maxpool_ctrl u_full (
        .clk(clk), .reset(reset), .en_ctrl(f_en),
        .rd_addr(f_rd_addr), .en_read(f_en_read), .rd_data(f_rd_data),
        .wr_addr(f_wr_addr), .wr_data(f_wr_data), .en_write(f_en_write),
        .busy(f_busy), .finish(f_finish), .dbg_state(f_dbg)
    );

    always @(posedge clk) begin
        if (f_en_read) f_rd_data <= f_in[f_rd_addr];
        if (f_en_write) begin
            f_out[f_wr_addr] <= f_wr_data;
            f_wcount <= f_wcount + 1;
        end
    end

    logic [46:0] s_all, m_all, f_all;
    assign s_all = {s_rd_addr, s_en_read, s_wr_addr, s_wr_data, s_en_write, s_busy, s_finish, s_dbg};
    assign m_all = {m_rd_addr, m_en_read, m_wr_addr, m_wr_data, m_en_write, m_busy, m_finish, m_dbg};
    assign f_all = {f_rd_addr, f_en_read, f_wr_addr, f_wr_data, f_en_write, f_busy, f_finish, f_dbg};

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_all, m_all, f_all} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got s=%h m=%h f=%h required all 0", s_all, m_all, f_all);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({s_all, m_all, f_all} !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got s=%h m=%h f=%h required all 0", i, s_all, m_all, f_all);
            end
        end
    endtask

    task automatic test_single_window();
        s_in[0] = 8'd5;
        s_in[1] = 8'hFD;
        s_in[2] = 8'd12;
        s_in[3] = 8'd7;
        s_out[0] = 8'hAA;
        s_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_checks++;
            if (s_en_read !== (j < 4)) begin
                n_fail++;
                $display("FAIL single_en_read c%0d: got %b required %b", j, s_en_read, (j < 4));
            end
            if (j < 4) begin
                n_checks++;
                if (s_rd_addr !== 16'(j)) begin
                    n_fail++;
                    $display("FAIL single_rd_addr c%0d: got %0d required %0d", j, s_rd_addr, j);
                end
            end
            n_checks++;
            if (s_en_write !== (j == 5)) begin
                n_fail++;
                $display("FAIL single_en_write c%0d: got %b required %b", j, s_en_write, (j == 5));
            end
            if (j == 5) begin
                n_checks++;
                if ({s_wr_addr, s_wr_data} !== {16'd0, 8'd12}) begin
                    n_fail++;
                    $display("FAIL single_write c%0d: got addr %0d data %0d required addr 0 data 12",
                             j, s_wr_addr, $signed(s_wr_data));
                end
            end
            n_checks++;
            if ({s_busy, s_finish} !== {(j < 6), (j >= 6)}) begin
                n_fail++;
                $display("FAIL single_busy_finish c%0d: got %b%b required %b%b",
                         j, s_busy, s_finish, (j < 6), (j >= 6));
            end
        end
        s_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_busy, s_finish, s_dbg} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_return_idle: got busy %b finish %b state %0d required 0 0 0",
                     s_busy, s_finish, s_dbg);
        end
        n_checks++;
        if (s_out[0] !== 8'd12) begin
            n_fail++;
            $display("FAIL single_ram: got %0d required 12", $signed(s_out[0]));
        end
    endtask

    task automatic run_small(input int a, input int b, input int c, input int d,
                             output logic [7:0] res, output int n_wr);
        s_in[0] = 8'(a);
        s_in[1] = 8'(b);
        s_in[2] = 8'(c);
        s_in[3] = 8'(d);
        res = 8'hXX;
        n_wr = 0;
        s_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (s_en_write === 1'b1) begin
                res = s_wr_data;
                n_wr++;
            end
            if (s_finish === 1'b1) break;
        end
        s_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_signed_ties();
        int          win [4][4];
        logic [7:0]  exp_raw [4];
        logic [7:0]  res;
        int          n_wr;
        win[0] = '{-128, -1, -1, -50};
        win[1] = '{-7, -7, -7, -7};
        win[2] = '{100, -100, 127, -128};
        win[3] = '{-2, -2, -3, -1};
        exp_raw = '{8'hFF, 8'hF9, 8'd127, 8'hFF};
        for (int t = 0; t < 4; t++) begin
            run_small(win[t][0], win[t][1], win[t][2], win[t][3], res, n_wr);
            n_checks++;
            if (n_wr !== 1 || res !== pool_exp(exp_raw[t])) begin
                n_fail++;
                $display("FAIL signed_window%0d: got %0d writes data %0d required 1 write data %0d",
                         t, n_wr, $signed(res), $signed(pool_exp(exp_raw[t])));
            end
        end
    endtask

    task automatic test_addressing();
        logic [15:0] rdq[$];
        logic [23:0] wq[$];
        int          exp_mid [8];
        int          exp_rd_idx [8];
        int          exp_rd_val [8];
        int          done_cycle;
        logic        overlap;
        exp_mid    = '{-11, -9, -3, -1, 5, 7, 13, 15};
        exp_rd_idx = '{4, 5, 6, 7, 28, 29, 30, 31};
        exp_rd_val = '{2, 3, 6, 7, 26, 27, 30, 31};
        for (int i = 0; i < 32; i++) m_in[i] = 8'(i - 16);
        done_cycle = -1;
        overlap = 1'b0;
        m_en = 1'b1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (m_en_read === 1'b1) rdq.push_back(m_rd_addr);
            if (m_en_write === 1'b1) wq.push_back({m_wr_addr, m_wr_data});
            if (m_en_read === 1'b1 && m_en_write === 1'b1) overlap = 1'b1;
            if (m_finish === 1'b1) begin
                done_cycle = j;
                break;
            end
        end
        m_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done_cycle != 48) begin
            n_fail++;
            $display("FAIL mid_run_length: got %0d cycles required 48", done_cycle);
        end
        n_checks++;
        if (overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rd_wr_overlap: got %b required 0", overlap);
        end
        n_checks++;
        if (wq.size() != 8 || rdq.size() != 32) begin
            n_fail++;
            $display("FAIL mid_counts: got %0d writes %0d reads required 8 writes 32 reads",
                     wq.size(), rdq.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < wq.size()) begin
                n_checks++;
                if (wq[i] !== {16'(i), pool_exp(8'(exp_mid[i]))}) begin
                    n_fail++;
                    $display("FAIL mid_write%0d: got addr %0d data %0d required addr %0d data %0d",
                             i, wq[i][23:8], $signed(wq[i][7:0]), i, $signed(pool_exp(8'(exp_mid[i]))));
                end
            end
            if (exp_rd_idx[i] < rdq.size()) begin
                n_checks++;
                if (rdq[exp_rd_idx[i]] !== 16'(exp_rd_val[i])) begin
                    n_fail++;
                    $display("FAIL mid_read%0d: got %0d required %0d",
                             exp_rd_idx[i], rdq[exp_rd_idx[i]], exp_rd_val[i]);
                end
            end
        end
    endtask

    task automatic test_mid_run_reset();
        int wc0;
        for (int i = 0; i < 32768; i++) f_in[i] = 8'((i * 97 + 13) ^ (i >> 4));
        wc0 = f_wcount;
        f_en = 1'b1;
        for (int j = 0; j <= 101; j++) @(negedge clk);
        f_en = 1'b0;
        n_checks++;
        if ({f_en_write, f_wr_addr} !== {1'b1, 16'd16}) begin
            n_fail++;
            $display("FAIL midreset_pre: got en_write %b addr %0d required 1 16", f_en_write, f_wr_addr);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({f_en_read, f_en_write, f_busy, f_finish, f_dbg, f_wr_addr, f_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL midreset_drop: got rd %b wr %b busy %b fin %b st %0d addr %0d data %0d required all 0",
                     f_en_read, f_en_write, f_busy, f_finish, f_dbg, f_wr_addr, f_wr_data);
        end
        @(negedge clk);
        n_checks++;
        if (f_wcount - wc0 != 16) begin
            n_fail++;
            $display("FAIL midreset_no_write: got %0d writes required 16", f_wcount - wc0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_full_run();
        int         wc0, j, bad, first_bad;
        logic       overlap;
        logic [7:0] v, mx, got_bad, exp_bad;
        wc0 = f_wcount;
        overlap = 1'b0;
        f_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({f_en_read, f_rd_addr} !== {1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL full_restart: got en_read %b addr %0d required 1 0", f_en_read, f_rd_addr);
        end
        j = 0;
        while (f_finish !== 1'b1 && j < 50000) begin
            @(negedge clk);
            j++;
            if (f_en_read === 1'b1 && f_en_write === 1'b1) overlap = 1'b1;
        end
        n_checks++;
        if (j != 49152) begin
            n_fail++;
            $display("FAIL full_run_length: got %0d cycles required 49152", j);
        end
        n_checks++;
        if (overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rd_wr_overlap: got %b required 0", overlap);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({f_finish, f_busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL full_finish_hold%0d: got finish %b busy %b required 1 0", i, f_finish, f_busy);
            end
        end
        f_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({f_finish, f_dbg} !== 4'b0) begin
            n_fail++;
            $display("FAIL full_finish_release: got finish %b state %0d required 0 0", f_finish, f_dbg);
        end
        n_checks++;
        if (f_wcount - wc0 != 8192) begin
            n_fail++;
            $display("FAIL full_write_count: got %0d required 8192", f_wcount - wc0);
        end
        bad = 0;
        first_bad = -1;
        got_bad = 8'd0;
        exp_bad = 8'd0;
        for (int ch = 0; ch < 32; ch++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    int base, oa;
                    base = ch * 1024 + r * 64 + c * 2;
                    oa = ch * 256 + r * 16 + c;
                    mx = f_in[base];
                    v = f_in[base + 1];  if ($signed(v) > $signed(mx)) mx = v;
                    v = f_in[base + 32]; if ($signed(v) > $signed(mx)) mx = v;
                    v = f_in[base + 33]; if ($signed(v) > $signed(mx)) mx = v;
                    if (f_out[oa] !== pool_exp(mx)) begin
                        if (bad == 0) begin
                            first_bad = oa;
                            got_bad = f_out[oa];
                            exp_bad = pool_exp(mx);
                        end
                        bad++;
                    end
                end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_ram: got %0d bad entries (first at %0d: %0d vs %0d) required 0",
                     bad, first_bad, $signed(got_bad), $signed(exp_bad));
        end
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_signed_ties();
        test_addressing();
        test_mid_run_reset();
        test_full_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
